seg_pattern_decoder: RTL and testbench

SEG_PATTERN_DECODER -- requirements
Module: seg_pattern_decoder

---
 rtl/seg_pattern_decoder.sv | 81 ++++++++
 tb/tb_seg_pattern_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder: pairs of active-low 7-seg patterns -> one hex byte; ports clk, clr (async active-low), in_valid/in_ready/seg_in, out_valid/out_ready/out_byte, err, err_count (only with SEG_ERRCNT_EN)
module seg_pattern_decoder #(
  parameter logic LSD_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] seg_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       err
`ifdef SEG_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam logic [1:0] WAIT_FIRST  = 2'd0;
  localparam logic [1:0] WAIT_SECOND = 2'd1;
  localparam logic [1:0] FULL        = 2'd2;
  logic [1:0] state;
  logic [3:0] digit;
  logic [4:0] dec;
  logic       acc;
  logic       bad;
  always_comb begin
    dec = 5'h00;
    case (seg_in)
      8'hC0: dec = 5'h10;
      8'hF9: dec = 5'h11;
      8'hA4: dec = 5'h12;
      8'hB0: dec = 5'h13;
      8'h99: dec = 5'h14;
      8'h92: dec = 5'h15;
      8'h82: dec = 5'h16;
      8'hF8: dec = 5'h17;
      8'h80: dec = 5'h18;
      8'h90: dec = 5'h19;
      8'h88: dec = 5'h1A;
      8'h83: dec = 5'h1B;
      8'hC6: dec = 5'h1C;
      8'hA1: dec = 5'h1D;
      8'h86: dec = 5'h1E;
      8'h8E: dec = 5'h1F;
      default: dec = 5'h00;
    endcase
  end
  assign in_ready  = state != FULL;
  assign out_valid = state == FULL;
  assign acc       = in_valid && in_ready && seg_in != 8'hFF;
  assign bad       = acc && !dec[4];
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= WAIT_FIRST;
      digit    <= 4'h0;
      out_byte <= 8'h00;
      err      <= 1'b0;
    end else begin
      err <= bad;
      if (bad) begin
        state <= WAIT_FIRST;
        digit <= 4'h0;
      end else if (acc && state == WAIT_FIRST) begin
        digit <= dec[3:0];
        state <= WAIT_SECOND;
      end else if (acc && state == WAIT_SECOND) begin
        out_byte <= LSD_FIRST ? {dec[3:0], digit} : {digit, dec[3:0]};
        state    <= FULL;
      end else if (state == FULL && out_ready) begin
        state <= WAIT_FIRST;
      end
    end
  end
`ifdef SEG_ERRCNT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) err_count <= 8'h00;
    else if (bad && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end
`endif
endmodule

// File: tb/tb_seg_pattern_decoder.sv
// tb_seg_pattern_decoder: random and directed stimulus against a table-driven reference model, both digit orders
module tb_seg_pattern_decoder;
  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic       out_ready = 1'b0;
  logic       a_in_ready, a_out_valid, a_err;
  logic       b_in_ready, b_out_valid, b_err;
  logic [7:0] a_out_byte, b_out_byte;
`ifdef SEG_ERRCNT_EN
  logic [7:0] a_err_count, b_err_count;
`endif
  int errors = 0;
  int checks = 0;
  int dig [256];
  logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic       m_full, m_have, m_err;
  logic [3:0] m_first;
  logic [7:0] m_lsd, m_msd, m_cnt;
  logic       was_err;
  always #5 clk = ~clk;
  seg_pattern_decoder #(.LSD_FIRST(1'b1)) u_lsd (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready), .seg_in(seg_in),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_byte(a_out_byte), .err(a_err)
`ifdef SEG_ERRCNT_EN
    , .err_count(a_err_count)
`endif
  );
  seg_pattern_decoder #(.LSD_FIRST(1'b0)) u_msd (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready), .seg_in(seg_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_byte(b_out_byte), .err(b_err)
`ifdef SEG_ERRCNT_EN
    , .err_count(b_err_count)
`endif
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic compare_all();
    chk("a_in_ready", {7'd0, a_in_ready}, {7'd0, !m_full});
    chk("b_in_ready", {7'd0, b_in_ready}, {7'd0, !m_full});
    chk("a_out_valid", {7'd0, a_out_valid}, {7'd0, m_full});
    chk("b_out_valid", {7'd0, b_out_valid}, {7'd0, m_full});
    chk("a_out_byte", a_out_byte, m_lsd);
    chk("b_out_byte", b_out_byte, m_msd);
    chk("a_err", {7'd0, a_err}, {7'd0, m_err});
    chk("b_err", {7'd0, b_err}, {7'd0, m_err});
`ifdef SEG_ERRCNT_EN
    chk("a_err_count", a_err_count, m_cnt);
    chk("b_err_count", b_err_count, m_cnt);
`endif
  endtask
  task automatic model_reset();
    m_full = 0; m_have = 0; m_err = 0; m_first = 0;
    m_lsd = 0; m_msd = 0; m_cnt = 0;
  endtask
  task automatic cyc(input logic v, input logic [7:0] s, input logic r);
    in_valid = v; seg_in = s; out_ready = r;
    @(posedge clk);
    m_err = 0;
    if (m_full) begin
      if (r) m_full = 0;
    end else if (v && s != 8'hFF) begin
      if (dig[s] < 0) begin
        m_have = 0; m_err = 1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
      end else if (!m_have) begin
        m_have = 1; m_first = 4'(dig[s]);
      end else begin
        m_have = 0; m_full = 1;
        m_lsd = {4'(dig[s]), m_first};
        m_msd = {m_first, 4'(dig[s])};
      end
    end
    #1;
    compare_all();
    if (a_err) was_err = 1;
  endtask
  task automatic mid_reset();
    #2 clr = 0;
    #1;
    model_reset();
    compare_all();
    #2 clr = 1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) dig[i] = -1;
    for (int i = 0; i < 16; i++) dig[tbl[i]] = i;
    model_reset();
    was_err = 0;
    #1 compare_all();
    #11 clr = 1;
    cyc(1, 8'h92, 1); cyc(1, 8'hA4, 1);
    chk("seq_25_valid", {7'd0, a_out_valid}, 8'h01);
    chk("seq_25_byte", a_out_byte, 8'h25);
    cyc(0, 8'hFF, 1);
    chk("seq_25_done", {7'd0, a_in_ready}, 8'h01);
    cyc(1, 8'h8E, 0); cyc(1, 8'hC0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'hF9, 0);
      chk("hold_f0_byte", b_out_byte, 8'hF0);
      chk("hold_ready", {7'd0, b_in_ready}, 8'h00);
    end
    cyc(0, 8'hFF, 1);
    cyc(1, 8'h99, 1); cyc(1, 8'h55, 1);
    chk("bad55_err", {7'd0, a_err}, 8'h01);
    cyc(1, 8'h80, 1);
    chk("err_one_cycle", {7'd0, a_err}, 8'h00);
    cyc(1, 8'h90, 1);
    chk("seq_98_byte", a_out_byte, 8'h98);
`ifdef SEG_ERRCNT_EN
    chk("cnt_one", a_err_count, 8'h01);
`endif
    cyc(0, 8'hFF, 1);
    was_err = 0;
    cyc(1, 8'hF9, 1); cyc(1, 8'hFF, 1); cyc(1, 8'hFF, 1); cyc(1, 8'hF8, 1);
    chk("seq_71_byte", a_out_byte, 8'h71);
    chk("blank_no_err", {7'd0, was_err}, 8'h00);
    cyc(0, 8'hFF, 1);
    cyc(1, 8'h40, 1);
    chk("dp_on_err", {7'd0, a_err}, 8'h01);
    cyc(1, 8'hC6, 1);
    mid_reset();
    cyc(1, 8'h86, 1); cyc(1, 8'hA1, 1);
    chk("seq_de_byte", a_out_byte, 8'hDE);
    cyc(0, 8'hFF, 1);
    for (int i = 0; i < 300; i++) cyc(1, 8'(8'h55 ^ (i & 8'h0F)), 1);
`ifdef SEG_ERRCNT_EN
    chk("cnt_sat", a_err_count, 8'hFF);
`endif
    mid_reset();
    for (int i = 0; i < 1500; i++) begin
      int k;
      logic [7:0] s;
      k = $urandom_range(0, 9);
      s = k < 6 ? tbl[$urandom_range(0, 15)] : k == 6 ? 8'hFF :
          k == 7 ? (tbl[$urandom_range(0, 15)] & 8'h7F) : 8'($urandom);
      cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0);
      if (i % 250 == 249) mid_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
